// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PIPE receiver-detect types and constants
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ASSERT = 3'd1,
        WAIT   = 3'd2,
        EVAL   = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5
    } rx_detect_state_e;

    localparam logic [2:0] RXSTATUS_RX_PRESENT = 3'b011;

    localparam logic [5:0] LINK_WIDTH_X0  = 6'd0;
    localparam logic [5:0] LINK_WIDTH_X1  = 6'd1;
    localparam logic [5:0] LINK_WIDTH_X2  = 6'd2;
    localparam logic [5:0] LINK_WIDTH_X4  = 6'd4;
    localparam logic [5:0] LINK_WIDTH_X8  = 6'd8;
    localparam logic [5:0] LINK_WIDTH_X16 = 6'd16;

    // Largest legal link width not exceeding a contiguous lane count
    function automatic logic [5:0] pow2_floor(input logic [4:0] cnt);
        logic [5:0] width;
        if (cnt >= 5'd16)     width = LINK_WIDTH_X16;
        else if (cnt >= 5'd8) width = LINK_WIDTH_X8;
        else if (cnt >= 5'd4) width = LINK_WIDTH_X4;
        else if (cnt >= 5'd2) width = LINK_WIDTH_X2;
        else if (cnt >= 5'd1) width = LINK_WIDTH_X1;
        else                  width = LINK_WIDTH_X0;
        return width;
    endfunction

endpackage

// File: rtl/pcie_lane_width_calc.sv
// rtl/pcie_lane_width_calc.sv - contiguous detected-lane count reduced to a legal link width
module pcie_lane_width_calc
    import pcie_phy_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0] i_detected,
    output logic [5:0]           o_width
);

    logic [4:0] w_count;
    logic       w_run;

    // Count detected lanes starting at bit 0 until the first missing lane
    always_comb begin
        w_count = 5'd0;
        w_run   = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_run && i_detected[i]) begin
                w_count = w_count + 5'd1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign o_width = pow2_floor(w_count);

endmodule

// File: rtl/pcie_rx_detect_ctrl.sv
// rtl/pcie_rx_detect_ctrl.sv - PIPE receiver-detection sequencer with retries; lane reversal under PCIE_LANE_REVERSAL_EN
module pcie_rx_detect_ctrl
    import pcie_phy_pkg::*;
#(
    parameter int MAX_NUM_LANES  = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [MAX_NUM_LANES-1:0]   phy_phystatus_i,
    input  logic [3*MAX_NUM_LANES-1:0] phy_rxstatus_i,
    output logic                       phy_txdetectrx_o,
    output logic [MAX_NUM_LANES-1:0]   lane_status_o,
    output logic [5:0]                 link_width_o,
    output logic                       lane_reversed_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       fail_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    rx_detect_state_e r_state;
    rx_detect_state_e w_next_state;

    logic [MAX_NUM_LANES-1:0] r_seen;
    logic [MAX_NUM_LANES-1:0] r_detected;
    logic [TW-1:0]            r_timeout;
    logic [RW-1:0]            r_retries;
    logic [MAX_NUM_LANES-1:0] r_lane_status;
    logic [5:0]               r_link_width;
    logic                     r_fail;

    logic [MAX_NUM_LANES-1:0] w_rx_present;
    logic [MAX_NUM_LANES-1:0] w_new_lanes;
    logic                     w_all_seen;
    logic                     w_timeout_hit;
    logic                     w_retry;
    logic [5:0]               w_width_norm;
    logic [5:0]               w_width;
    logic                     w_reversed;

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_rx_present
        assign w_rx_present[g] = (phy_rxstatus_i[3*g +: 3] == RXSTATUS_RX_PRESENT);
    end

    // A pulse on the exit cycle still counts toward both "all seen" and capture
    assign w_new_lanes   = phy_phystatus_i & ~r_seen;
    assign w_all_seen    = &(r_seen | phy_phystatus_i);
    assign w_timeout_hit = (r_timeout == TO_LAST);
    assign w_retry       = (w_width == LINK_WIDTH_X0) && (r_retries < RETRY_MAX);

    pcie_lane_width_calc #(
        .NUM_LANES (MAX_NUM_LANES)
    ) u_calc_norm (
        .i_detected (r_detected),
        .o_width    (w_width_norm)
    );

`ifdef PCIE_LANE_REVERSAL_EN
    logic [MAX_NUM_LANES-1:0] w_det_rev;
    logic [5:0]               w_width_rev;
    logic                     r_lane_reversed;

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_rev
        assign w_det_rev[g] = r_detected[MAX_NUM_LANES-1-g];
    end

    pcie_lane_width_calc #(
        .NUM_LANES (MAX_NUM_LANES)
    ) u_calc_rev (
        .i_detected (w_det_rev),
        .o_width    (w_width_rev)
    );

    // Reversed order wins only when strictly wider; ties stay in normal order
    always_comb begin
        w_width    = w_width_norm;
        w_reversed = 1'b0;
        if (w_width_rev > w_width_norm) begin
            w_width    = w_width_rev;
            w_reversed = 1'b1;
        end
    end

    // Reversal flag is latched alongside the other results
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_lane_reversed <= 1'b0;
        end else if (r_state == EVAL && !w_retry) begin
            r_lane_reversed <= w_reversed;
        end
    end

    assign lane_reversed_o = r_lane_reversed;
`else
    assign w_width         = w_width_norm;
    assign w_reversed      = 1'b0;
    assign lane_reversed_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next_state = ASSERT;
            ASSERT:  w_next_state = WAIT;
            WAIT:    if (w_all_seen || w_timeout_hit) w_next_state = EVAL;
            EVAL:    w_next_state = w_retry ? GAP : DONE;
            GAP:     w_next_state = ASSERT;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        phy_txdetectrx_o = (r_state == ASSERT) || (r_state == WAIT);
        busy_o           = (r_state != IDLE);
        done_o           = (r_state == DONE);
    end

    // Lane capture, timeout/retry counters and result latching
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_seen        <= '0;
            r_detected    <= '0;
            r_timeout     <= '0;
            r_retries     <= '0;
            r_lane_status <= '0;
            r_link_width  <= LINK_WIDTH_X0;
            r_fail        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_seen     <= '0;
                        r_detected <= '0;
                        r_retries  <= '0;
                    end
                end
                ASSERT: begin
                    r_timeout <= '0;
                end
                WAIT: begin
                    r_seen     <= r_seen | phy_phystatus_i;
                    r_detected <= r_detected | (w_new_lanes & w_rx_present);
                    if (!w_timeout_hit) begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                EVAL: begin
                    if (w_retry) begin
                        r_retries <= r_retries + 1'b1;
                    end else begin
                        r_lane_status <= r_detected;
                        r_link_width  <= w_width;
                        r_fail        <= (w_width == LINK_WIDTH_X0);
                    end
                end
                GAP: begin
                    r_seen     <= '0;
                    r_detected <= '0;
                end
                default: ;
            endcase
        end
    end

    assign lane_status_o = r_lane_status;
    assign link_width_o  = r_link_width;
    assign fail_o        = r_fail;

endmodule

// File: tb/tb_pcie_rx_detect_ctrl.sv
// tb/tb_pcie_rx_detect_ctrl.sv - directed self-checking bench for pcie_rx_detect_ctrl
module tb_pcie_rx_detect_ctrl;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int MR = 2;

    logic           clk_i;
    logic           rst_ni;
    logic           start_i;
    logic [N-1:0]   phy_phystatus_i;
    logic [3*N-1:0] phy_rxstatus_i;
    logic           phy_txdetectrx_o;
    logic [N-1:0]   lane_status_o;
    logic [5:0]     link_width_o;
    logic           lane_reversed_o;
    logic           busy_o;
    logic           done_o;
    logic           fail_o;

    int n_checks = 0;
    int n_errors = 0;

    pcie_rx_detect_ctrl #(
        .MAX_NUM_LANES  (N),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .phy_phystatus_i  (phy_phystatus_i),
        .phy_rxstatus_i   (phy_rxstatus_i),
        .phy_txdetectrx_o (phy_txdetectrx_o),
        .lane_status_o    (lane_status_o),
        .link_width_o     (link_width_o),
        .lane_reversed_o  (lane_reversed_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .fail_o           (fail_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done_o && k < budget) begin
            tick();
            k++;
        end
        if (!done_o) check_val(tag, 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [5:0] width,
                                input logic [N-1:0] lanes, input logic fail, input logic rev);
        check_val({tag, "_done"},  32'(done_o),          32'd1);
        check_val({tag, "_width"}, 32'(link_width_o),    32'(width));
        check_val({tag, "_lanes"}, 32'(lane_status_o),   32'(lanes));
        check_val({tag, "_fail"},  32'(fail_o),          32'(fail));
        check_val({tag, "_rev"},   32'(lane_reversed_o), 32'(rev));
    endtask

    // Hold PhyStatus on every lane with a fixed RxStatus pattern until completion
    task automatic run_hold(input string tag, input logic [3*N-1:0] rx);
        phy_phystatus_i = '1;
        phy_rxstatus_i  = rx;
        do_start();
        wait_done({tag, "_timeout"}, 200);
        phy_phystatus_i = '0;
        phy_rxstatus_i  = '0;
    endtask

    initial begin
        int rises;
        int highs;
        logic prev;

        rst_ni          = 1'b0;
        start_i         = 1'b0;
        phy_phystatus_i = '0;
        phy_rxstatus_i  = '0;
        repeat (3) tick();

        check_val("rst_txdet", 32'(phy_txdetectrx_o), 32'd0);
        check_val("rst_busy",  32'(busy_o),           32'd0);
        check_val("rst_done",  32'(done_o),           32'd0);
        check_val("rst_width", 32'(link_width_o),     32'd0);
        check_val("rst_lanes", 32'(lane_status_o),    32'd0);
        check_val("rst_fail",  32'(fail_o),           32'd0);
        rst_ni = 1'b1;
        tick();

        // All four lanes present, pulsed on the third WAIT cycle
        do_start();
        check_val("t1_txdet_rise", 32'(phy_txdetectrx_o), 32'd1);
        check_val("t1_busy",       32'(busy_o),           32'd1);
        tick();
        tick();
        tick();
        phy_phystatus_i = 4'b1111;
        phy_rxstatus_i  = 12'h6DB;
        tick();
        phy_phystatus_i = '0;
        phy_rxstatus_i  = '0;
        check_val("t1_eval_txdet", 32'(phy_txdetectrx_o), 32'd0);
        check_val("t1_eval_done",  32'(done_o),           32'd0);
        tick();
        check_result("t1", 6'd4, 4'b1111, 1'b0, 1'b0);
        tick();
        check_val("t1_done_pulse", 32'(done_o),       32'd0);
        check_val("t1_idle_busy",  32'(busy_o),       32'd0);
        check_val("t1_hold_width", 32'(link_width_o), 32'd4);

        // Lanes 0..2 present, lane 3 absent
        run_hold("t2", 12'h0DB);
        check_result("t2", 6'd2, 4'b0111, 1'b0, 1'b0);
        tick();

        // Only lane 0 reports: attempt ends on timeout after 16 WAIT cycles
        do_start();
        tick();
        phy_phystatus_i = 4'b0001;
        phy_rxstatus_i  = 12'h003;
        tick();
        phy_phystatus_i = '0;
        phy_rxstatus_i  = '0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (13) tick();
        check_val("t3_wait_txdet", 32'(phy_txdetectrx_o), 32'd1);
        tick();
        check_val("t3_eval_txdet", 32'(phy_txdetectrx_o), 32'd0);
        tick();
        check_result("t3", 6'd1, 4'b0001, 1'b0, 1'b0);
        tick();

        // Nothing ever detected: three attempts then failure
        rises = 0;
        highs = 0;
        prev  = 1'b0;
        do_start();
        for (int k = 0; k < 200; k++) begin
            if (phy_txdetectrx_o && !prev) rises++;
            if (phy_txdetectrx_o) highs++;
            prev = phy_txdetectrx_o;
            if (done_o) break;
            tick();
        end
        check_val("t4_attempts",  32'(rises), 32'd3);
        check_val("t4_high_cyc",  32'(highs), 32'd51);
        check_result("t4", 6'd0, 4'b0000, 1'b1, 1'b0);
        tick();

        // Lanes 3 and 2 present only
        run_hold("t5", 12'h6C0);
`ifdef PCIE_LANE_REVERSAL_EN
        check_result("t5", 6'd2, 4'b1100, 1'b0, 1'b1);
`else
        check_result("t5", 6'd0, 4'b1100, 1'b1, 1'b0);
`endif
        tick();

        // Lanes 0 and 3 present: tie keeps normal order
        run_hold("t6", 12'h603);
        check_result("t6", 6'd1, 4'b1001, 1'b0, 1'b0);
        tick();

        // Reset in the middle of WAIT, then a fresh attempt
        do_start();
        tick();
        tick();
        check_val("t7_pre_txdet", 32'(phy_txdetectrx_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        check_val("t7_rst_txdet", 32'(phy_txdetectrx_o), 32'd0);
        check_val("t7_rst_busy",  32'(busy_o),           32'd0);
        check_val("t7_rst_width", 32'(link_width_o),     32'd0);
        check_val("t7_rst_lanes", 32'(lane_status_o),    32'd0);
        rst_ni = 1'b1;
        tick();
        run_hold("t7", 12'h6DB);
        check_result("t7", 6'd4, 4'b1111, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
